pipe_alu4: RTL and testbench

- Four-stage ALU pipeline: register-file operand read, ALU execute, register writeback, data-memory store.
- Every cycle it accepts one instruction (rs1, rs2, rd, func, addr).
- The result is written to regbank[rd] and then to mem[addr].
- Standalone datapath for pipeline exercises; no instruction fetch or decode.

---
 rtl/pipe_alu4_pkg.sv | 24 ++
 rtl/pipe_alu4_alu.sv | 34 +++
 rtl/pipe_alu4.sv | 108 ++++++++++
 tb/tb_pipe_alu4.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_alu4_pkg.sv
// pipe_alu4_pkg: shared default widths and ALU opcode encoding for the
// pipe_alu4 four-stage datapath.
package pipe_alu4_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 10;

    // ALU operation codes; encodings 12-15 are unused and produce zero.
    typedef enum logic [3:0] {
        FN_ADD   = 4'd0,
        FN_SUB   = 4'd1,
        FN_MUL   = 4'd2,
        FN_PASSA = 4'd3,
        FN_PASSB = 4'd4,
        FN_AND   = 4'd5,
        FN_OR    = 4'd6,
        FN_XOR   = 4'd7,
        FN_NOTA  = 4'd8,
        FN_NOTB  = 4'd9,
        FN_SHR   = 4'd10,
        FN_SHL   = 4'd11
    } aluFunc_e;

endpackage

// File: rtl/pipe_alu4_alu.sv
// pipe_alu4_alu: purely combinational ALU used by the execute stage.
// All results wrap to DATA_W bits; the multiply keeps the low half.
module pipe_alu4_alu
    import pipe_alu4_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
)(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [3:0]        func_i,
    output logic [DATA_W-1:0] result_o
);

    // Select the operation; unused opcodes fall through to zero.
    always_comb begin
        result_o = '0;
        case (aluFunc_e'(func_i))
            FN_ADD:   result_o = a_i + b_i;
            FN_SUB:   result_o = a_i - b_i;
            FN_MUL:   result_o = a_i * b_i;
            FN_PASSA: result_o = a_i;
            FN_PASSB: result_o = b_i;
            FN_AND:   result_o = a_i & b_i;
            FN_OR:    result_o = a_i | b_i;
            FN_XOR:   result_o = a_i ^ b_i;
            FN_NOTA:  result_o = ~a_i;
            FN_NOTB:  result_o = ~b_i;
            FN_SHR:   result_o = a_i >> 1;
            FN_SHL:   result_o = a_i << 1;
            default:  result_o = '0;
        endcase
    end

endmodule

// File: rtl/pipe_alu4.sv
// pipe_alu4: four-stage ALU pipeline (operand read, execute, register
// writeback, memory store), one instruction accepted every cycle.
// Optional macro PIPE_FWD_EN: operand read bypasses results still in the
// pipe (execute-stage result first, then writeback-stage result).
// Without it a consumer must be issued at least 3 cycles after its producer.
module pipe_alu4
    import pipe_alu4_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int REG_DEPTH = 2**ADDR_W,
    parameter int MEM_DEPTH = 2**ADDR_W
)(
    input  logic              clk1,
    input  logic              rst_n,
    output logic [DATA_W-1:0] Z,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [ADDR_W-1:0] rd,
    input  logic [3:0]        func,
    input  logic [ADDR_W-1:0] addr
);

    // Storage is never cleared by reset so preloaded contents survive it.
    logic [DATA_W-1:0] regbank [0:REG_DEPTH-1];
    logic [DATA_W-1:0] mem     [0:MEM_DEPTH-1];

    // Stage 1: operands and latched instruction fields.
    logic [DATA_W-1:0] opA_d, opB_d;
    logic [DATA_W-1:0] opA_q, opB_q;
    logic [ADDR_W-1:0] rdS1_q, addrS1_q;
    logic [3:0]        funcS1_q;
    logic              validS1_q;

    // Stage 2: registered ALU result.
    logic [DATA_W-1:0] aluResult;
    logic [DATA_W-1:0] z_q;
    logic [ADDR_W-1:0] rdS2_q, addrS2_q;
    logic              validS2_q;

    // Stage 3: result carried on towards the memory store.
    logic [DATA_W-1:0] zS3_q;
    logic [ADDR_W-1:0] addrS3_q;
    logic              validS3_q;

    assign Z = z_q;

    pipe_alu4_alu #(
        .DATA_W   (DATA_W)
    ) u_alu (
        .a_i      (opA_q),
        .b_i      (opB_q),
        .func_i   (funcS1_q),
        .result_o (aluResult)
    );

    // Operand fetch, optionally bypassing results that have not reached regbank yet.
    always_comb begin
        opA_d = regbank[rs1];
        opB_d = regbank[rs2];
`ifdef PIPE_FWD_EN
        if (validS2_q && (rdS2_q == rs1)) opA_d = z_q;
        if (validS2_q && (rdS2_q == rs2)) opB_d = z_q;
        if (validS1_q && (rdS1_q == rs1)) opA_d = aluResult;
        if (validS1_q && (rdS1_q == rs2)) opB_d = aluResult;
`endif
    end

    // Pipeline registers; reset empties every stage and clears the valid bits.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            opA_q     <= '0;
            opB_q     <= '0;
            rdS1_q    <= '0;
            addrS1_q  <= '0;
            funcS1_q  <= '0;
            validS1_q <= 1'b0;
            z_q       <= '0;
            rdS2_q    <= '0;
            addrS2_q  <= '0;
            validS2_q <= 1'b0;
            zS3_q     <= '0;
            addrS3_q  <= '0;
            validS3_q <= 1'b0;
        end else begin
            opA_q     <= opA_d;
            opB_q     <= opB_d;
            rdS1_q    <= rd;
            addrS1_q  <= addr;
            funcS1_q  <= func;
            validS1_q <= 1'b1;
            z_q       <= aluResult;
            rdS2_q    <= rdS1_q;
            addrS2_q  <= addrS1_q;
            validS2_q <= validS1_q;
            zS3_q     <= z_q;
            addrS3_q  <= addrS2_q;
            validS3_q <= validS2_q;
        end
    end

    // Writeback to regbank and store to mem, suppressed for stages emptied by reset.
    always_ff @(posedge clk1) begin
        if (validS2_q) regbank[rdS2_q] <= z_q;
        if (validS3_q) mem[addrS3_q]   <= zS3_q;
    end

endmodule

// File: tb/tb_pipe_alu4.sv
// tb_pipe_alu4: table-driven and randomized checks of pipe_alu4 against a
// reference model that tracks when each result becomes architecturally
// visible in regbank and mem.
module tb_pipe_alu4;

    logic        clk1;
    logic        rst_n;
    logic [15:0] Z;
    logic [9:0]  rs1, rs2, rd, addr;
    logic [3:0]  func;

    pipe_alu4 dut (
        .clk1  (clk1),
        .rst_n (rst_n),
        .Z     (Z),
        .rs1   (rs1),
        .rs2   (rs2),
        .rd    (rd),
        .func  (func),
        .addr  (addr)
    );

`ifdef PIPE_FWD_EN
    localparam logic [15:0] HZ_NEAR = 16'd7;
`else
    localparam logic [15:0] HZ_NEAR = 16'd20;
`endif

    typedef struct {
        logic [9:0]  s1;
        logic [9:0]  s2;
        logic [9:0]  d;
        logic [3:0]  f;
        logic [9:0]  a;
        logic [15:0] expZ;
    } vecT;

    typedef struct {
        logic [15:0] res;
        logic [9:0]  idx;
        int          edgeNo;
    } wrT;

    vecT         tab [0:16];
    wrT          regQ [$];
    wrT          memQ [$];
    logic [15:0] refReg [0:1023];
    logic [15:0] refMem [0:1023];
    logic [15:0] prevRes;
    logic [15:0] expZNow;
    int          edgeNow;
    int          passCnt;
    int          totalCnt;

    // Free-running pipeline clock.
    initial begin
        clk1 = 1'b0;
        forever #5 clk1 = ~clk1;
    end

    // Safety net so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void setVec(int i, int s1, int s2, int d, int f, int a, int e);
        tab[i].s1   = 10'(s1);
        tab[i].s2   = 10'(s2);
        tab[i].d    = 10'(d);
        tab[i].f    = 4'(f);
        tab[i].a    = 10'(a);
        tab[i].expZ = 16'(e);
    endfunction

    function automatic logic [15:0] refAlu(input logic [15:0] a, input logic [15:0] b,
                                           input logic [3:0] f);
        longint ua, ub, r;
        ua = longint'(a);
        ub = longint'(b);
        case (f)
            4'd0:    r = ua + ub;
            4'd1:    r = ua + 65536 - ub;
            4'd2:    r = ua * ub;
            4'd3:    r = ua;
            4'd4:    r = ub;
            4'd5:    r = longint'(a & b);
            4'd6:    r = longint'(a | b);
            4'd7:    r = longint'(a ^ b);
            4'd8:    r = 65535 - ua;
            4'd9:    r = 65535 - ub;
            4'd10:   r = ua / 2;
            4'd11:   r = ua * 2;
            default: r = 0;
        endcase
        return 16'(r % 65536);
    endfunction

    // Apply every write the hardware has performed by edge lim.
    function automatic void commitWrites(input int lim);
        while (regQ.size() > 0 && regQ[0].edgeNo + 2 <= lim) begin
            refReg[regQ[0].idx] = regQ[0].res;
            void'(regQ.pop_front());
        end
        while (memQ.size() > 0 && memQ[0].edgeNo + 3 <= lim) begin
            refMem[memQ[0].idx] = memQ[0].res;
            void'(memQ.pop_front());
        end
    endfunction

    // Register value as seen by a reader; with bypass, newest pending result wins.
    function automatic logic [15:0] readModel(input logic [9:0] idx);
        logic [15:0] v;
        v = refReg[idx];
`ifdef PIPE_FWD_EN
        foreach (regQ[j]) if (regQ[j].idx == idx) v = regQ[j].res;
`endif
        return v;
    endfunction

    function automatic void modelReset();
        commitWrites(edgeNow);
        regQ.delete();
        memQ.delete();
        prevRes = '0;
        expZNow = '0;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act !== exp)
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else
            passCnt++;
    endtask

    // Drive one instruction, take the sampling edge and advance the model.
    task automatic applyStimulus(input logic [9:0] s1, input logic [9:0] s2, input logic [9:0] d,
                                 input logic [3:0] f, input logic [9:0] a);
        logic [15:0] res;
        wrT          w;
        rs1  = s1;
        rs2  = s2;
        rd   = d;
        func = f;
        addr = a;
        @(posedge clk1);
        edgeNow++;
        commitWrites(edgeNow - 1);
        res      = refAlu(readModel(s1), readModel(s2), f);
        w.res    = res;
        w.idx    = d;
        w.edgeNo = edgeNow;
        regQ.push_back(w);
        w.idx    = a;
        memQ.push_back(w);
        expZNow  = prevRes;
        prevRes  = res;
        #1;
    endtask

    task automatic applyIdle();
        applyStimulus(10'd1023, 10'd1023, 10'd1023, 4'd12, 10'd1023);
    endtask

    task automatic preloadAndReset(input bit rnd);
        logic [15:0] v;
        rst_n = 1'b0;
        @(posedge clk1);
        #1;
        for (int k = 0; k < 1024; k++) begin
            v = rnd ? 16'($urandom) : 16'(k);
            dut.regbank[k] = v;
            refReg[k]      = v;
            dut.mem[k]     = 16'hA000 ^ 16'(k);
            refMem[k]      = 16'hA000 ^ 16'(k);
        end
        modelReset();
        checkOutput("resetZ", 32'(Z), 32'd0);
        @(negedge clk1);
        rst_n = 1'b1;
    endtask

    task automatic runTable(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            applyStimulus(tab[i].s1, tab[i].s2, tab[i].d, tab[i].f, tab[i].a);
            if (i > lo) checkOutput("tableZ", 32'(Z), 32'(tab[i-1].expZ));
        end
        applyIdle();
        checkOutput("tableZ", 32'(Z), 32'(tab[hi].expZ));
        applyIdle();
        applyIdle();
        for (int i = lo; i <= hi; i++) begin
            checkOutput("tableMem", 32'(dut.mem[tab[i].a]), 32'(tab[i].expZ));
            checkOutput("tableReg", 32'(dut.regbank[tab[i].d]), 32'(tab[i].expZ));
        end
    endtask

    function automatic logic [9:0] pickIdx();
        if ($urandom_range(0, 1) == 1) return 10'($urandom_range(0, 15));
        return 10'($urandom_range(0, 1023));
    endfunction

    // Main test sequence.
    initial begin
        int diffs;
        rst_n    = 1'b0;
        rs1      = '0;
        rs2      = '0;
        rd       = '0;
        func     = '0;
        addr     = '0;
        edgeNow  = 0;
        passCnt  = 0;
        totalCnt = 0;
        prevRes  = '0;
        expZNow  = '0;

        setVec(0,  3,   3,   10,  0,  125, 6);
        setVec(1,  4,   4,   12,  1,  126, 0);
        setVec(2,  5,   5,   14,  2,  127, 25);
        setVec(3,  6,   6,   200, 3,  128, 6);
        setVec(4,  7,   7,   201, 4,  129, 7);
        setVec(5,  8,   8,   202, 5,  130, 8);
        setVec(6,  9,   9,   203, 6,  131, 9);
        setVec(7,  10,  10,  204, 7,  132, 0);
        setVec(8,  11,  0,   205, 8,  133, 16'hFFF4);
        setVec(9,  0,   12,  206, 9,  134, 16'hFFF3);
        setVec(10, 6,   0,   207, 10, 135, 3);
        setVec(11, 6,   0,   208, 11, 136, 12);
        setVec(12, 300, 300, 209, 2,  137, 24464);
        setVec(13, 5,   7,   210, 12, 138, 0);
        setVec(14, 5,   7,   211, 13, 139, 0);
        setVec(15, 5,   7,   212, 14, 140, 0);
        setVec(16, 5,   7,   213, 15, 141, 0);

        $display("[TB] directed vectors");
        preloadAndReset(1'b0);
        runTable(0, 7);
        preloadAndReset(1'b0);
        runTable(8, 16);

        $display("[TB] hazard sequence");
        preloadAndReset(1'b0);
        applyStimulus(10'd3,  10'd4, 10'd20,  4'd0, 10'd300);
        applyStimulus(10'd20, 10'd0, 10'd600, 4'd3, 10'd301);
        checkOutput("hazProducerZ", 32'(Z), 32'd7);
        applyStimulus(10'd20, 10'd0, 10'd601, 4'd3, 10'd302);
        checkOutput("hazGap1Z", 32'(Z), 32'(HZ_NEAR));
        applyStimulus(10'd20, 10'd0, 10'd602, 4'd3, 10'd303);
        checkOutput("hazGap2Z", 32'(Z), 32'(HZ_NEAR));
        applyIdle();
        checkOutput("hazGap3Z", 32'(Z), 32'd7);

        $display("[TB] reset with instructions in flight");
        applyStimulus(10'd50, 10'd51, 10'd700, 4'd0, 10'd700);
        applyStimulus(10'd52, 10'd53, 10'd701, 4'd1, 10'd701);
        applyStimulus(10'd54, 10'd55, 10'd702, 4'd6, 10'd702);
        checkOutput("preResetZ", 32'(Z), 32'hFFFF);
        rst_n = 1'b0;
        #1;
        checkOutput("asyncResetZ", 32'(Z), 32'd0);
        modelReset();
        repeat (3) @(posedge clk1);
        #1;
        for (int idx = 700; idx <= 702; idx++) begin
            checkOutput("resetMem", 32'(dut.mem[idx]), 32'(refMem[idx]));
            checkOutput("resetReg", 32'(dut.regbank[idx]), 32'(refReg[idx]));
        end
        checkOutput("resetMemKept", 32'(dut.mem[702]), 32'hA2BE);
        @(negedge clk1);
        rst_n = 1'b1;

        $display("[TB] randomized stream");
        preloadAndReset(1'b1);
        for (int n = 0; n < 200; n++) begin
            applyStimulus(pickIdx(), pickIdx(), pickIdx(), 4'($urandom_range(0, 15)),
                          10'($urandom_range(0, 1023)));
            checkOutput("randZ", 32'(Z), 32'(expZNow));
        end
        repeat (3) applyIdle();
        commitWrites(edgeNow);
        diffs = 0;
        for (int k = 0; k < 1024; k++) if (dut.regbank[k] !== refReg[k]) diffs++;
        checkOutput("randRegbankDiffs", 32'(diffs), 32'd0);
        diffs = 0;
        for (int k = 0; k < 1024; k++) if (dut.mem[k] !== refMem[k]) diffs++;
        checkOutput("randMemDiffs", 32'(diffs), 32'd0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
